// File: rtl/ff_chk_pkg.sv
// Shared definitions for the flip-flop conversion checker: mode encoding,
// FSM state type and the golden next-state function.
package ff_chk_pkg;

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } chk_state_t;

    // Golden model; SR with a=b=1 is undefined and handled by the caller.
    function automatic logic ff_next(input logic [1:0] mode,
                                     input logic       a,
                                     input logic       b,
                                     input logic       q);
        logic nq;
        case (mode)
            MODE_D:  nq = a;
            MODE_T:  nq = q ^ a;
            MODE_JK: nq = (a & ~q) | (~b & q);
            MODE_SR: nq = a | (~b & q);
            default: nq = q;
        endcase
        return nq;
    endfunction

    function automatic logic sr_illegal(input logic [1:0] mode,
                                        input logic       a,
                                        input logic       b);
        return (mode == MODE_SR) && a && b;
    endfunction

endpackage

// File: rtl/ff_conv_checker_if.sv
// Stimulus/observation bundle between a conversion bench and the checker.
// master drives stimulus and the device q, slave is the checker.
interface ff_conv_checker_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic             a;
    logic             b;
    logic             dut_q;
    logic             checking;
    logic             err;
    logic             illegal_sr;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] cyc_cnt;

    modport master (
        output start, stop, mode, a, b, dut_q,
        input  checking, err, illegal_sr, done, err_cnt, cyc_cnt
    );

    modport slave (
        input  start, stop, mode, a, b, dut_q,
        output checking, err, illegal_sr, done, err_cnt, cyc_cnt
    );

endinterface

// File: rtl/ff_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module ff_chk_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ff_conv_checker.sv
// Hardware checker for converted flip-flops: predicts q one edge ahead and
// counts mismatches. FF_CHK_FIRST_FAIL_EN adds the first-failure latch.
//
// state | meaning
// IDLE  | waiting for start
// SYNC  | one edge: seed prediction from the device's own q
// CHECK | compare device q every edge, advance prediction
// DONE  | run finished, counters held
module ff_conv_checker
    import ff_chk_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    ff_conv_checker_if.slave    bus
`ifdef FF_CHK_FIRST_FAIL_EN
    ,
    output logic [CNT_W-1:0]    first_fail_cyc,
    output logic                first_fail_vld
`endif
);

    chk_state_t state_q;
    chk_state_t state_d;

    logic q_exp_q;
    logic skip_q;
    logic err_q;
    logic illegal_q;

    logic run_start;
    logic in_run;
    logic cmp_en;
    logic mismatch;
    logic sr_bad;
    logic q_base;

    assign in_run   = (state_q == ST_SYNC) || (state_q == ST_CHECK);
    assign cmp_en   = (state_q == ST_CHECK) && !skip_q;
    assign mismatch = cmp_en && (bus.dut_q != q_exp_q);
    assign sr_bad   = in_run && sr_illegal(bus.mode, bus.a, bus.b);
    // SYNC seeds from the device; CHECK runs free on the prediction.
    assign q_base   = (state_q == ST_SYNC) ? bus.dut_q : q_exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_SYNC;
                    run_start = 1'b1;
                end
            end
            ST_SYNC: begin
                state_d = bus.stop ? ST_IDLE : ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.stop || (STOP_ON_ERR && mismatch)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_d   = ST_SYNC;
                    run_start = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_exp_q   <= 1'b0;
            skip_q    <= 1'b0;
            err_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            err_q     <= mismatch;
            illegal_q <= sr_bad;
            if (run_start) begin
                skip_q <= 1'b0;
            end else if (in_run) begin
                // Undefined SR input: resync to the device and skip one compare.
                if (sr_bad) begin
                    q_exp_q <= bus.dut_q;
                    skip_q  <= 1'b1;
                end else begin
                    q_exp_q <= ff_next(bus.mode, bus.a, bus.b, q_base);
                    skip_q  <= 1'b0;
                end
            end
        end
    end

    ff_chk_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (mismatch),
        .cnt   (bus.err_cnt)
    );

    ff_chk_sat_cnt #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (cmp_en),
        .cnt   (bus.cyc_cnt)
    );

    assign bus.checking   = in_run;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.err        = err_q;
    assign bus.illegal_sr = illegal_q;

`ifdef FF_CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] cyc_this;

    // Report the failing compare's own ordinal, i.e. the count including it.
    assign cyc_this = (bus.cyc_cnt == '1) ? bus.cyc_cnt : bus.cyc_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_cyc <= '0;
            first_fail_vld <= 1'b0;
        end else if (run_start) begin
            first_fail_cyc <= '0;
            first_fail_vld <= 1'b0;
        end else if (mismatch && !first_fail_vld) begin
            first_fail_cyc <= cyc_this;
            first_fail_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ff_conv_checker.sv
// Directed bench for ff_conv_checker: one free-running instance and one with
// STOP_ON_ERR=1, driven by a behavioural flip-flop standing in for the device.
module tb_ff_conv_checker;
    import ff_chk_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ff_conv_checker_if #(.CNT_W(16)) bus0 ();
    ff_conv_checker_if #(.CNT_W(16)) bus1 ();

`ifdef FF_CHK_FIRST_FAIL_EN
    logic [15:0] ffc0, ffc1;
    logic        ffv0, ffv1;
`endif

    ff_conv_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
`ifdef FF_CHK_FIRST_FAIL_EN
        ,
        .first_fail_cyc (ffc0),
        .first_fail_vld (ffv0)
`endif
    );

    ff_conv_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef FF_CHK_FIRST_FAIL_EN
        ,
        .first_fail_cyc (ffc1),
        .first_fail_vld (ffv1)
`endif
    );

    int   passed = 0;
    int   total = 0;
    int   err_pulses = 0;
    logic dev_q = 1'b0;

    // Behavioural device; SR with s=r=1 holds.
    function automatic logic dev_next(input logic [1:0] m, input logic x, input logic y,
                                      input logic q);
        logic r;
        case (m)
            MODE_D:  r = x;
            MODE_T:  r = x ? ~q : q;
            MODE_JK: r = x ? (y ? ~q : 1'b1) : (y ? 1'b0 : q);
            default: r = (x && y) ? q : (x ? 1'b1 : (y ? 1'b0 : q));
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc0(input logic x, input logic y, input logic inv, input logic stp);
        bus0.a     = x;
        bus0.b     = y;
        bus0.stop  = stp;
        bus0.dut_q = dev_q ^ inv;
        tick();
        dev_q = dev_next(bus0.mode, x, y, dev_q);
        if (bus0.err === 1'b1) err_pulses++;
        bus0.stop = 1'b0;
    endtask

    task automatic start0(input logic [1:0] m);
        bus0.mode  = m;
        bus0.start = 1'b1;
        cyc0(1'b0, 1'b0, 1'b0, 1'b0);
        bus0.start = 1'b0;
        err_pulses = 0;
    endtask

    task automatic test_reset();
        total++; if (bus0.checking !== 1'b0) $display("FAIL rst_checking: got %b want 0", bus0.checking); else passed++;
        total++; if (bus0.err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus0.err); else passed++;
        total++; if (bus0.illegal_sr !== 1'b0) $display("FAIL rst_illegal: got %b want 0", bus0.illegal_sr); else passed++;
        total++; if (bus0.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus0.done); else passed++;
        total++; if (bus0.err_cnt !== 16'd0) $display("FAIL rst_err_cnt: got %0d want 0", bus0.err_cnt); else passed++;
        total++; if (bus0.cyc_cnt !== 16'd0) $display("FAIL rst_cyc_cnt: got %0d want 0", bus0.cyc_cnt); else passed++;
        rst_n = 1'b1;
        tick();
        total++; if (bus0.checking !== 1'b0) $display("FAIL idle_hold: checking got %b want 0", bus0.checking); else passed++;
    endtask

    task automatic test_d_mode();
        dev_q = 1'b0;
        start0(MODE_D);
        total++; if (bus0.checking !== 1'b1) $display("FAIL d_sync_checking: got %b want 1", bus0.checking); else passed++;
        cyc0(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (bus0.cyc_cnt !== 16'd0) $display("FAIL d_sync_nocmp: cyc_cnt got %0d want 0", bus0.cyc_cnt); else passed++;
        cyc0(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (bus0.cyc_cnt !== 16'd1) $display("FAIL d_first_cmp: cyc_cnt got %0d want 1", bus0.cyc_cnt); else passed++;
        cyc0(1'b1, 1'b0, 1'b0, 1'b0);
        cyc0(1'b0, 1'b0, 1'b0, 1'b0);
        cyc0(1'b1, 1'b0, 1'b0, 1'b0);
        cyc0(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus0.done !== 1'b1) $display("FAIL d_done: got %b want 1", bus0.done); else passed++;
        total++; if (bus0.checking !== 1'b0) $display("FAIL d_checking_off: got %b want 0", bus0.checking); else passed++;
        total++; if (bus0.cyc_cnt !== 16'd5) $display("FAIL d_cyc_cnt: got %0d want 5", bus0.cyc_cnt); else passed++;
        total++; if (bus0.err_cnt !== 16'd0) $display("FAIL d_err_cnt: got %0d want 0", bus0.err_cnt); else passed++;
        total++; if (err_pulses !== 0) $display("FAIL d_err_pulses: got %0d want 0", err_pulses); else passed++;
    endtask

    task automatic test_t_mode();
        start0(MODE_T);
        total++; if (bus0.cyc_cnt !== 16'd0) $display("FAIL t_restart_cyc: got %0d want 0", bus0.cyc_cnt); else passed++;
        total++; if (bus0.done !== 1'b0) $display("FAIL t_restart_done: got %b want 0", bus0.done); else passed++;
        cyc0(1'b1, 1'b0, 1'b0, 1'b0);
        cyc0(1'b0, 1'b0, 1'b0, 1'b0);
        cyc0(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus0.err !== 1'b0) $display("FAIL t_err_early: got %b want 0", bus0.err); else passed++;
        cyc0(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (bus0.err !== 1'b1) $display("FAIL t_err_pulse: got %b want 1", bus0.err); else passed++;
        cyc0(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus0.err !== 1'b0) $display("FAIL t_err_clear: got %b want 0", bus0.err); else passed++;
        cyc0(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus0.err_cnt !== 16'd1) $display("FAIL t_err_cnt: got %0d want 1", bus0.err_cnt); else passed++;
        total++; if (bus0.cyc_cnt !== 16'd5) $display("FAIL t_cyc_cnt: got %0d want 5", bus0.cyc_cnt); else passed++;
        total++; if (err_pulses !== 1) $display("FAIL t_err_pulses: got %0d want 1", err_pulses); else passed++;
    endtask

`ifdef FF_CHK_FIRST_FAIL_EN
    task automatic test_first_fail();
        start0(MODE_D);
        total++; if (ffv0 !== 1'b0) $display("FAIL ff_clear_vld: got %b want 0", ffv0); else passed++;
        cyc0(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            cyc0(i[0], 1'b0, (i == 4) || (i == 7), i == 8);
            if (i == 4) begin
                total++; if (ffv0 !== 1'b1) $display("FAIL ff_vld: got %b want 1", ffv0); else passed++;
                total++; if (ffc0 !== 16'd4) $display("FAIL ff_cyc: got %0d want 4", ffc0); else passed++;
            end
        end
        total++; if (ffc0 !== 16'd4) $display("FAIL ff_cyc_held: got %0d want 4", ffc0); else passed++;
        total++; if (bus0.err_cnt !== 16'd2) $display("FAIL ff_err_cnt: got %0d want 2", bus0.err_cnt); else passed++;
        total++; if (bus0.cyc_cnt !== 16'd8) $display("FAIL ff_cyc_cnt: got %0d want 8", bus0.cyc_cnt); else passed++;
    endtask
`endif

    task automatic test_sr_illegal();
        start0(MODE_SR);
        cyc0(1'b0, 1'b1, 1'b0, 1'b0);
        cyc0(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus0.illegal_sr !== 1'b0) $display("FAIL sr_no_illegal: got %b want 0", bus0.illegal_sr); else passed++;
        cyc0(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (bus0.illegal_sr !== 1'b1) $display("FAIL sr_illegal_pulse: got %b want 1", bus0.illegal_sr); else passed++;
        total++; if (bus0.cyc_cnt !== 16'd2) $display("FAIL sr_cyc_before_skip: got %0d want 2", bus0.cyc_cnt); else passed++;
        cyc0(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (bus0.cyc_cnt !== 16'd2) $display("FAIL sr_skip_cyc: got %0d want 2", bus0.cyc_cnt); else passed++;
        total++; if (bus0.err !== 1'b0) $display("FAIL sr_skip_err: got %b want 0", bus0.err); else passed++;
        total++; if (bus0.illegal_sr !== 1'b0) $display("FAIL sr_illegal_end: got %b want 0", bus0.illegal_sr); else passed++;
        cyc0(1'b0, 1'b1, 1'b0, 1'b1);
        total++; if (bus0.cyc_cnt !== 16'd3) $display("FAIL sr_cyc_final: got %0d want 3", bus0.cyc_cnt); else passed++;
        total++; if (bus0.err_cnt !== 16'd0) $display("FAIL sr_err_cnt: got %0d want 0", bus0.err_cnt); else passed++;
    endtask

    task automatic test_stop_on_err();
        bus1.mode  = MODE_JK;
        bus1.a     = 1'b1;
        bus1.b     = 1'b1;
        bus1.dut_q = 1'b0;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        total++; if (bus1.checking !== 1'b1) $display("FAIL soe_checking: got %b want 1", bus1.checking); else passed++;
        tick();
        total++; if (bus1.done !== 1'b1) $display("FAIL soe_done: got %b want 1", bus1.done); else passed++;
        total++; if (bus1.err !== 1'b1) $display("FAIL soe_err: got %b want 1", bus1.err); else passed++;
        total++; if (bus1.err_cnt !== 16'd1) $display("FAIL soe_err_cnt: got %0d want 1", bus1.err_cnt); else passed++;
        tick();
        total++; if (bus1.err_cnt !== 16'd1) $display("FAIL soe_err_cnt_held: got %0d want 1", bus1.err_cnt); else passed++;
        total++; if (bus1.done !== 1'b1) $display("FAIL soe_done_held: got %b want 1", bus1.done); else passed++;
    endtask

    task automatic test_reset_mid();
        bus0.mode  = MODE_D;
        bus0.a     = 1'b1;
        bus0.b     = 1'b0;
        bus0.dut_q = 1'b0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (4) tick();
        total++; if (bus0.err_cnt !== 16'd3) $display("FAIL mid_err_cnt: got %0d want 3", bus0.err_cnt); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus0.checking !== 1'b0) $display("FAIL mid_checking: got %b want 0", bus0.checking); else passed++;
        total++; if (bus0.err !== 1'b0) $display("FAIL mid_err: got %b want 0", bus0.err); else passed++;
        total++; if (bus0.err_cnt !== 16'd0) $display("FAIL mid_err_cnt_clr: got %0d want 0", bus0.err_cnt); else passed++;
        total++; if (bus0.cyc_cnt !== 16'd0) $display("FAIL mid_cyc_cnt_clr: got %0d want 0", bus0.cyc_cnt); else passed++;
        total++; if (bus0.done !== 1'b0) $display("FAIL mid_done: got %b want 0", bus0.done); else passed++;
        #2;
        rst_n = 1'b1;
        tick();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        total++; if (bus0.checking !== 1'b1) $display("FAIL mid_restart: got %b want 1", bus0.checking); else passed++;
        bus0.stop = 1'b1;
        tick();
        bus0.stop = 1'b0;
        total++; if (bus0.checking !== 1'b0) $display("FAIL sync_stop_checking: got %b want 0", bus0.checking); else passed++;
        total++; if (bus0.done !== 1'b0) $display("FAIL sync_stop_done: got %b want 0", bus0.done); else passed++;
    endtask

    initial begin
        bus0.start = 1'b0; bus0.stop = 1'b0; bus0.mode = MODE_D;
        bus0.a = 1'b0; bus0.b = 1'b0; bus0.dut_q = 1'b0;
        bus1.start = 1'b0; bus1.stop = 1'b0; bus1.mode = MODE_D;
        bus1.a = 1'b0; bus1.b = 1'b0; bus1.dut_q = 1'b0;
        repeat (2) tick();
        test_reset();
        test_d_mode();
        test_t_mode();
`ifdef FF_CHK_FIRST_FAIL_EN
        test_first_fail();
`endif
        test_sr_illegal();
        test_stop_on_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ff_conv_checker.md
# ff_conv_checker

Self-checking monitor that sits directly downstream of the converted flip-flops (SR-to-D, SR-to-JK, SR-to-T, plain D). Each cycle it samples the same stimulus that drives the device under check, runs a golden next-state model, compares the device's `q` one clock later, and counts mismatches. It lets the conversion benches report pass/fail in hardware instead of by reading `$monitor` output.

## Interface
- `CNT_W`, 16: width of the error and cycle counters.
- `STOP_ON_ERR`, 0: 1 means enter DONE on the first mismatch.
- `clk` in 1: sampling clock, the same clock that drives the device; rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a check run (honoured in IDLE and DONE).
- `stop` in 1: ends the run; takes effect in SYNC or CHECK.
- `mode` in 2: device type. 00 = D, 01 = T, 10 = JK, 11 = SR.
- `a` in 1: d / t / j / s, according to `mode`.
- `b` in 1: k / r. Ignored in D and T modes.
- `dut_q` in 1: `q` output of the device under check.
- `checking` out 1: high in SYNC and CHECK.
- `err` out 1: one-cycle pulse on a mismatch.
- `illegal_sr` out 1: one-cycle pulse when S=R=1 is sampled in SR mode.
- `done` out 1: high in DONE.
- `err_cnt` out CNT_W: number of mismatches; saturates.
- `cyc_cnt` out CNT_W: number of compared cycles; saturates.

## Operation
- FSM states are IDLE, SYNC, CHECK and DONE. Reset state is IDLE.
- IDLE → SYNC on `start`.
- SYNC lasts exactly one edge. It seeds `q_exp <= f(mode, a, b, dut_q)`, then goes to CHECK. If `stop` is high it goes to IDLE instead.
- CHECK, on every edge:
  - Compare `dut_q` against the `q_exp` held from the previous edge.
  - Then load `q_exp <= f(mode, a, b, q_exp)`.
  - `stop` moves the FSM to DONE.
  - If `STOP_ON_ERR`=1 and a mismatch occurs, move to DONE. The mismatch is still counted.
- DONE holds the counters. `start` re-enters SYNC and clears both counters.
- Golden model `f`:
  - D: q⁺ = a.
  - T: q⁺ = q ^ a.
  - JK: q⁺ = (a & ~q) | (~b & q).
  - SR: q⁺ = a | (~b & q), valid only when not (a & b).
- SR mode with a=b=1:
  - Pulse `illegal_sr`.
  - Load `q_exp` with the sampled `dut_q` value (resynchronise).
  - Set `skip`, so the next compare is neither counted nor flagged.
- Counter behaviour:
  - `cyc_cnt` increments on every non-skipped compare in CHECK.
  - `err_cnt` increments on every mismatch.
  - Both saturate at 2^CNT_W−1.
- Changing `mode` in CHECK is legal. The new model applies from that edge onward.

## Timing
- Reset values: IDLE, `checking`=0, `err`=0, `illegal_sr`=0, `done`=0, `err_cnt`=0, `cyc_cnt`=0, `q_exp`=0, `skip`=0.
- Reset is asynchronous. Asserting `rst_n` mid-run returns the block to IDLE immediately and clears all state.
- Compare latency: a stimulus sampled at edge k is checked against `dut_q` sampled at edge k+1.
- `err` is asserted for the cycle following edge k+1.
- The first compare happens on the first CHECK edge, i.e. the second edge after `start` is sampled.
- `start` and `stop` high on the same edge:
  - In IDLE, `start` wins.
  - In SYNC or CHECK, `stop` wins.
- `start` in SYNC or CHECK is ignored.
- A mismatch and `stop` on the same CHECK edge: the mismatch is counted, then the FSM enters DONE.
- `illegal_sr` and `err` can be asserted on the same cycle, because they come from different edges' data.

## Configuration
- Macro `FF_CHK_FIRST_FAIL_EN`.
- When defined:
  - Adds output `first_fail_cyc` [CNT_W], which latches `cyc_cnt` at the first mismatch of a run.
  - Adds output `first_fail_vld` [1], set at the same time.
  - Both clear on reset and on a run restart.
- When undefined, neither port exists and there is no latch logic.

## Structure
- Shared package `ff_chk_pkg` holds:
  - The `mode` encoding constants (`MODE_D`, `MODE_T`, `MODE_JK`, `MODE_SR`).
  - The FSM state typedef.
  - A function `ff_next(mode, a, b, q)` implementing `f`.
- Sub-module `ff_chk_sat_cnt` is a parameterised saturating counter with `clr` and `inc` inputs, instantiated twice.

## Test plan
- D mode, correct DUT, d = 0,1,0,1,0 over 5 CHECK cycles → `err_cnt`=0, `cyc_cnt`=5 after `stop`, `done`=1.
- T mode, DUT `q` forced inverted on the third CHECK cycle → single `err` pulse one cycle later, `err_cnt`=1.
- SR mode, s=r=1 for one cycle → `illegal_sr` pulse, and the next compare is skipped (`cyc_cnt` does not increment for it).
- `STOP_ON_ERR`=1, JK mode with j=k=1 and a DUT `q` stuck at 0 → DONE after the first mismatch, `err_cnt`=1.
- `rst_n` asserted low mid-CHECK with `err_cnt`=3 → all outputs return to 0 immediately; a new `start` re-enters SYNC.
- With `FF_CHK_FIRST_FAIL_EN` defined, mismatches at compared cycles 4 and 7 → `first_fail_cyc`=4 with `first_fail_vld`=1, and it does not change at the second mismatch.
